send_cmd_dispatcher: RTL and testbench

- Converts PCIe send doorbells (6-bit slot index plus signal) into send-command pulses with 25-bit DDR start addresses for the two packet senders (send_packet_1, send_packet_2).
- Sits between the PCIe send-control conduit and the send_packet_N_control conduits, in the DDR Avalon clock domain.
- Each port has its own queue, so one busy port never blocks the other.
- Commands are held back while DDR is not ready, and consecutive commands on a port are spaced by a programmable holdoff.

---
 rtl/send_cmd_dispatcher_if.sv | 28 ++
 rtl/send_cmd_dispatcher.sv | 125 ++++++++++++
 tb/tb_send_cmd_dispatcher.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/send_cmd_dispatcher_if.sv
// Doorbell in, per-port send commands out, plus queue/drop status.
interface send_cmd_dispatcher_if;
  logic [5:0]  pcie_send_control_start_ram_addr;
  logic        pcie_send_control_signal;
  logic        ddr_ready_ram_ready;
  logic [24:0] send_packet_1_control_start_ram_addr;
  logic        send_packet_1_control_cmd_send;
  logic [24:0] send_packet_2_control_start_ram_addr;
  logic        send_packet_2_control_cmd_send;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [5:0]  pending_1;
  logic [5:0]  pending_2;

  modport master (
    output pcie_send_control_start_ram_addr, pcie_send_control_signal, ddr_ready_ram_ready,
    input  send_packet_1_control_start_ram_addr, send_packet_1_control_cmd_send,
    input  send_packet_2_control_start_ram_addr, send_packet_2_control_cmd_send,
    input  overflow, drop_count, pending_1, pending_2
  );

  modport slave (
    input  pcie_send_control_start_ram_addr, pcie_send_control_signal, ddr_ready_ram_ready,
    output send_packet_1_control_start_ram_addr, send_packet_1_control_cmd_send,
    output send_packet_2_control_start_ram_addr, send_packet_2_control_cmd_send,
    output overflow, drop_count, pending_1, pending_2
  );
endinterface

// File: rtl/send_cmd_dispatcher.sv
// Turns PCIe send doorbells into spaced send-command pulses for two packet
// senders. Each port owns a queue of DDR start addresses and a small FSM.
module send_cmd_dispatcher #(
  parameter logic [24:0] BASE_ADDR  = 25'd0,
  parameter int          SLOT_SHIFT = 11,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CMD_GAP    = 64
) (
  input logic                 clock_clk,
  input logic                 reset_reset,
  send_cmd_dispatcher_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} st_e;

  logic          sig_q;
  logic          evt;
  logic          tgt;
  logic [24:0]   new_addr;
  st_e           st_q    [2];
  st_e           st_d    [2];
  logic [15:0]   cnt_q   [2];
  logic [15:0]   cnt_d   [2];
  logic [CW-1:0] count_q [2];
  logic [AW-1:0] wr_q    [2];
  logic [AW-1:0] rd_q    [2];
  logic [24:0]   mem_q   [2][FIFO_DEPTH];
  logic [24:0]   addr_q  [2];
  logic [1:0]    cmd_q;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          drop;
  logic          ovf_q;
  logic [7:0]    drop_q;

  // Rising edge of the doorbell level is one request; slot LSB picks the port.
  assign evt      = bus.pcie_send_control_signal & ~sig_q;
  assign tgt      = bus.pcie_send_control_start_ram_addr[0];
  assign new_addr = BASE_ADDR + (25'(bus.pcie_send_control_start_ram_addr) << SLOT_SHIFT);

  // Accept or drop the request; a full queue still accepts if it pops this cycle.
  always_comb begin
    push = '0;
    pop  = '0;
    drop = 1'b0;
    for (int p = 0; p < 2; p++) pop[p] = (st_q[p] == ISSUE);
    if (evt) begin
      if (count_q[tgt] != CW'(FIFO_DEPTH) || pop[tgt]) push[tgt] = 1'b1;
      else                                              drop      = 1'b1;
    end
  end

  // Per-port FSM: wait for work and DDR, issue one entry, then hold off.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      st_d[p]  = st_q[p];
      cnt_d[p] = cnt_q[p];
      case (st_q[p])
        IDLE:    if (count_q[p] != '0 && bus.ddr_ready_ram_ready) st_d[p] = ISSUE;
        ISSUE: begin
          st_d[p]  = HOLDOFF;
          cnt_d[p] = 16'(CMD_GAP);
        end
        HOLDOFF: begin
          // Counter reaches 0 on the last HOLDOFF cycle, giving CMD_GAP+2 spacing.
          cnt_d[p] = cnt_q[p] - 16'd1;
          if (cnt_q[p] == 16'd1) st_d[p] = IDLE;
        end
        default: st_d[p] = IDLE;
      endcase
    end
  end

  // Queue storage is not reset; occupancy and pointers define validity.
  always_ff @(posedge clock_clk) begin
    for (int p = 0; p < 2; p++)
      if (push[p]) mem_q[p][wr_q[p]] <= new_addr;
  end

  // State, queue bookkeeping, registered outputs and drop statistics.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      sig_q  <= 1'b1;
      cmd_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
      for (int p = 0; p < 2; p++) begin
        st_q[p]    <= IDLE;
        cnt_q[p]   <= '0;
        count_q[p] <= '0;
        wr_q[p]    <= '0;
        rd_q[p]    <= '0;
        addr_q[p]  <= '0;
      end
    end else begin
      sig_q <= bus.pcie_send_control_signal;
      for (int p = 0; p < 2; p++) begin
        st_q[p]    <= st_d[p];
        cnt_q[p]   <= cnt_d[p];
        count_q[p] <= count_q[p] + CW'(push[p]) - CW'(pop[p]);
        cmd_q[p]   <= pop[p];
        if (push[p]) wr_q[p] <= wr_q[p] + AW'(1);
        if (pop[p]) begin
          rd_q[p]   <= rd_q[p] + AW'(1);
          addr_q[p] <= mem_q[p][rd_q[p]];
        end
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign bus.send_packet_1_control_start_ram_addr = addr_q[0];
  assign bus.send_packet_1_control_cmd_send       = cmd_q[0];
  assign bus.send_packet_2_control_start_ram_addr = addr_q[1];
  assign bus.send_packet_2_control_cmd_send       = cmd_q[1];
  assign bus.overflow                             = ovf_q;
  assign bus.drop_count                           = drop_q;
  assign bus.pending_1                            = 6'(count_q[0]);
  assign bus.pending_2                            = 6'(count_q[1]);
endmodule

// File: tb/tb_send_cmd_dispatcher.sv
// Bench for send_cmd_dispatcher: scoreboard of expected pulses per port plus
// a vector table and hand-written corner-case sequences.
module tb_send_cmd_dispatcher;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  send_cmd_dispatcher_if bus();

  send_cmd_dispatcher #(
    .BASE_ADDR(25'd0), .SLOT_SHIFT(11), .FIFO_DEPTH(8), .CMD_GAP(GAP)
  ) dut (
    .clock_clk(clk),
    .reset_reset(rst),
    .bus(bus)
  );

  typedef struct { logic [24:0] addr; int at; } exp_t;
  typedef struct { logic [5:0] slot; logic [24:0] addr; } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   t1[$];
  logic rst_d;
  logic [1:0]  cmd_prev = '0;
  logic [24:0] a1_prev = '0;
  logic [24:0] a2_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_d <= rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pulse_seen(input int p, input logic [24:0] a);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (p == 0) t1.push_back(cyc);
    if (p == 0 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (p == 1 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    if (!have) chk($sformatf("p%0d_unexpected_pulse", p + 1), 32'(a), 32'hFFFF_FFFF);
    else begin
      chk($sformatf("p%0d_addr", p + 1), 32'(a), 32'(e.addr));
      if (e.at >= 0) chk($sformatf("p%0d_pulse_cycle", p + 1), 32'(cyc), 32'(e.at));
    end
  endtask

  // Output monitor: pulses are popped against the scoreboard, pulse width is
  // one cycle, and addresses only move when a pulse rises.
  always @(negedge clk) begin
    if (bus.send_packet_1_control_cmd_send) begin
      chk("p1_pulse_width", 32'(cmd_prev[0]), 32'd0);
      pulse_seen(0, bus.send_packet_1_control_start_ram_addr);
    end else if (rst_d == 1'b0)
      chk("p1_addr_stable", 32'(bus.send_packet_1_control_start_ram_addr), 32'(a1_prev));
    if (bus.send_packet_2_control_cmd_send) begin
      chk("p2_pulse_width", 32'(cmd_prev[1]), 32'd0);
      pulse_seen(1, bus.send_packet_2_control_start_ram_addr);
    end else if (rst_d == 1'b0)
      chk("p2_addr_stable", 32'(bus.send_packet_2_control_start_ram_addr), 32'(a2_prev));
    cmd_prev <= {bus.send_packet_2_control_cmd_send, bus.send_packet_1_control_cmd_send};
    a1_prev  <= bus.send_packet_1_control_start_ram_addr;
    a2_prev  <= bus.send_packet_2_control_start_ram_addr;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One doorbell: level high for one cycle, then low for one cycle.
  // kind 0: expect nothing, 1: expect pulse at exact latency, 2: any time.
  task automatic ring(input logic [5:0] s, input logic [24:0] a, input int kind);
    exp_t e;
    bus.pcie_send_control_start_ram_addr = s;
    bus.pcie_send_control_signal = 1'b1;
    tick();
    e.addr = a;
    e.at   = (kind == 1) ? cyc + 2 : -1;
    if (kind != 0) begin
      if (s[0]) q2.push_back(e);
      else      q1.push_back(e);
    end
    bus.pcie_send_control_signal = 1'b0;
    tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd1"},  32'(bus.send_packet_1_control_cmd_send), 32'd0);
    chk({tag, "_cmd2"},  32'(bus.send_packet_2_control_cmd_send), 32'd0);
    chk({tag, "_addr1"}, 32'(bus.send_packet_1_control_start_ram_addr), 32'd0);
    chk({tag, "_addr2"}, 32'(bus.send_packet_2_control_start_ram_addr), 32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow), 32'd0);
    chk({tag, "_drops"}, 32'(bus.drop_count), 32'd0);
    chk({tag, "_pend1"}, 32'(bus.pending_1), 32'd0);
    chk({tag, "_pend2"}, 32'(bus.pending_2), 32'd0);
  endtask

  initial begin
    vec_t vt[6];
    bit   seen;
    vt[0] = '{6'd3,  25'h0001800};
    vt[1] = '{6'd0,  25'h0000000};
    vt[2] = '{6'd63, 25'h001F800};
    vt[3] = '{6'd10, 25'h0005000};
    vt[4] = '{6'd62, 25'h001F000};
    vt[5] = '{6'd33, 25'h0010800};

    bus.pcie_send_control_start_ram_addr = '0;
    bus.pcie_send_control_signal = 1'b0;
    bus.ddr_ready_ram_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single requests with DDR ready: exact latency and address per slot.
    foreach (vt[i]) begin
      ring(vt[i].slot, vt[i].addr, 1);
      repeat (GAP + 6) tick();
      chk("table_pend1", 32'(bus.pending_1), 32'd0);
      chk("table_pend2", 32'(bus.pending_2), 32'd0);
    end

    // DDR not ready: requests queue up, then drain with CMD_GAP+2 spacing.
    bus.ddr_ready_ram_ready = 1'b0;
    t1.delete();
    ring(6'd0, 25'h0000000, 2);
    ring(6'd2, 25'h0001000, 2);
    ring(6'd4, 25'h0002000, 2);
    tick();
    chk("hold_pend1", 32'(bus.pending_1), 32'd3);
    chk("hold_pend2", 32'(bus.pending_2), 32'd0);
    bus.ddr_ready_ram_ready = 1'b1;
    repeat (3 * (GAP + 2) + 6) tick();
    chk("drain_pulses", 32'(t1.size()), 32'd3);
    if (t1.size() == 3) begin
      chk("spacing_0_1", 32'(t1[1] - t1[0]), 32'(GAP + 2));
      chk("spacing_1_2", 32'(t1[2] - t1[1]), 32'(GAP + 2));
    end
    chk("drain_pend1", 32'(bus.pending_1), 32'd0);

    // Overflow: ten requests into an eight-deep queue.
    bus.ddr_ready_ram_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      ring(6'(2 * i), 25'(i) << 12, (i < 8) ? 2 : 0);
    tick();
    chk("ovf_pend1", 32'(bus.pending_1), 32'd8);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_drops", 32'(bus.drop_count), 32'd2);
    bus.ddr_ready_ram_ready = 1'b1;
    repeat (8 * (GAP + 2) + 8) tick();
    chk("ovf_drained", 32'(bus.pending_1), 32'd0);
    chk("ovf_all_issued", 32'(q1.size()), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("ovf_clr_flag",  32'(bus.overflow), 32'd0);
    chk("ovf_clr_drops", 32'(bus.drop_count), 32'd0);

    // Port 1 issues at full speed while port 2 sits in HOLDOFF.
    ring(6'd1, 25'h0000800, 1);
    ring(6'd0, 25'h0000000, 1);
    repeat (GAP + 8) tick();
    chk("indep_pend1", 32'(bus.pending_1), 32'd0);
    chk("indep_pend2", 32'(bus.pending_2), 32'd0);

    // Level held high across reset release is not a request.
    rst = 1'b1;
    bus.pcie_send_control_start_ram_addr = 6'd6;
    bus.pcie_send_control_signal = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("held_pend1", 32'(bus.pending_1), 32'd0);
    chk("held_pend2", 32'(bus.pending_2), 32'd0);
    bus.pcie_send_control_signal = 1'b0;
    tick();
    ring(6'd6, 25'h0003000, 1);
    repeat (GAP + 6) tick();
    chk("held_after_pend1", 32'(bus.pending_1), 32'd0);

    // Reset during the pulse cycle flushes the queue; nothing follows.
    bus.ddr_ready_ram_ready = 1'b0;
    ring(6'd0, 25'h0000000, 2);
    ring(6'd2, 25'h0001000, 0);
    ring(6'd4, 25'h0002000, 0);
    chk("mid_pend1", 32'(bus.pending_1), 32'd3);
    bus.ddr_ready_ram_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.send_packet_1_control_cmd_send) seen = 1'b1;
    end
    chk("mid_pulse_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("mid_reset");
    rst = 1'b0;
    repeat (4 * (GAP + 2)) tick();
    chk("mid_after_pend1", 32'(bus.pending_1), 32'd0);

    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    chk("end_q2_empty", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
